dca_matrix_lsu_txn_sequencer: RTL
=================================

DCA_MATRIX_LSU_TXN_SEQUENCER -- requirements
Module: dca_matrix_lsu_txn_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- BW_ADDR, 32, byte-address width.
- BW_AXI_DATA, 64, AXI data width in bits; BYTES = BW_AXI_DATA/8.
- MAX_NUM_ROW, 16, maximum rows per instruction.
- MAX_NUM_COL, 16, maximum columns per instruction; MAX_NUM_COL*8 <= 256*BYTES is required.
- NUM_OUTSTANDING, 4, maximum issued-but-uncompleted transactions.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rstnn, in, 1, asynchronous active-low reset.
- enable, in, 1, clock-enable for all state except the outstanding counter.
- busy, out, 1, high when not IDLE.
- inst_valid, in, 1, instruction offered.
- inst_ready, out, 1, instruction accepted on inst_valid & inst_ready.
- inst_opcode, in, 2, 0 = nop, 1 = read, 2 = write, 3 = nop.
- inst_addr, in, BW_ADDR, byte address of row 0.
- inst_stride, in, BW_ADDR, byte stride between rows.
- inst_num_row_m1, in, clog2(MAX_NUM_ROW), rows minus one.
- inst_num_col_m1, in, clog2(MAX_NUM_COL), columns minus one.
- inst_elem_lsa, in, 2, log2 of element bytes (1 to 8 bytes).
- txn_valid, out, 1, transaction offered.
- txn_ready, in, 1, transaction accepted on txn_valid & txn_ready.
- txn_write, out, 1, 1 = write, 0 = read.
- txn_addr, out, BW_ADDR, start byte address, beat-aligned for every transaction except the first of a row.
- txn_len, out, 8, AXI length (beats minus one).
- txn_row, out, clog2(MAX_NUM_ROW), row index.
- txn_last, out, 1, final transaction of the instruction.
- done_valid, in, 1, one transaction completed.
- inst_done, out, 1, one-cycle pulse when the instruction is fully complete.

Function
REQ-003 The FSM SHALL have the states IDLE, CALC, ISSUE, SPLIT and DRAIN, and SHALL advance only while enable = 1.
REQ-004 In IDLE, inst_ready SHALL be 1; on acceptance all inst_* fields are latched and the FSM goes to CALC (nop: goes to DRAIN).
REQ-005 CALC SHALL take one cycle to compute the row byte count (num_col_m1+1) << elem_lsa, the end address = addr + bytes - 1, and txn_len = (end >> log2 BYTES) - (addr >> log2 BYTES); txn_valid first rises 2 cycles after acceptance.
REQ-006 In ISSUE, txn_valid SHALL be 1 unless the outstanding count equals NUM_OUTSTANDING; txn fields SHALL stay stable until the handshake completes.
REQ-007 On a txn handshake, the row index SHALL increment and the address SHALL advance by stride (modulo 2^BW_ADDR), and the FSM SHALL return to CALC; after the last row it SHALL go to DRAIN.
REQ-008 The outstanding counter SHALL increment on a txn handshake, decrement on done_valid, stay unchanged when both occur together, ignore done_valid at 0, and count regardless of enable.
REQ-009 A stall at a full counter SHALL NOT be released by a same-cycle done_valid; txn_valid reasserts the next cycle.
REQ-010 In DRAIN, once the counter is 0 the block SHALL pulse inst_done and go to IDLE.
REQ-011 txn_last SHALL be 1 only on the final transaction of the last row.
REQ-012 txn_write SHALL equal (opcode == 2).

Reset
REQ-013 While rstnn = 0, the block SHALL be in IDLE with all counters and registers at 0, and the outputs SHALL be: inst_ready 1; busy, txn_valid, txn_last and inst_done 0; all other outputs 0.
REQ-014 Reset mid-instruction SHALL abandon the instruction, with no further transactions and no inst_done.

Configuration
REQ-015 With DCA_LSU_4KB_SPLIT_EN defined, a row whose bytes cross a 4 KB boundary SHALL be issued as two transactions:
- first: addr, with len up to the boundary; the FSM enters SPLIT;
- second: the boundary address, with the remaining len.
The row index SHALL advance only after the second.
REQ-016 Without DCA_LSU_4KB_SPLIT_EN, every row SHALL be exactly one transaction, and the SPLIT state SHALL be absent.

Verification
REQ-017 Read, addr 0x1000, stride 0x40, num_row_m1 3, num_col_m1 7, lsa 2 -> four txns at 0x1000, 0x1040, 0x1080 and 0x10C0, each with len 3 and row 0..3; last on the 4th; 4 done -> inst_done.
REQ-018 Write, addr 0x1004, 1 row, num_col_m1 7, lsa 2 -> one txn at addr 0x1004, len 4, txn_write 1, last 1.
REQ-019 6 rows, no done_valid, txn_ready 1 -> exactly 4 handshakes, then txn_valid 0; one done -> 5th txn the next cycle.
REQ-020 addr 0x0FF0, 1 row, num_col_m1 7, lsa 2 -> with the macro: txn 0x0FF0 len 1, then txn 0x1000 len 1 with last 1; without the macro: one txn 0x0FF0 len 3.
REQ-021 rstnn low after 2 handshakes -> all outputs at reset values; after release inst_ready 1, no txns.
REQ-022 opcode 0 accepted with no outstanding transactions -> no txn, inst_done pulse 1 cycle after acceptance, then inst_ready 1.

Source files
------------

// File: rtl/dca_matrix_lsu_txn_sequencer.sv
// Matrix load/store transaction sequencer: turns one row/column instruction
// into one AXI-style burst request per row (optionally split at 4 KB pages),
// limits issued-but-uncompleted bursts, and signals instruction completion.
// Optional feature: define DCA_LSU_4KB_SPLIT_EN to split rows that cross a
// 4 KB boundary into two bursts (adds the SPLIT state).
module dca_matrix_lsu_txn_sequencer #(
  parameter int BW_ADDR         = 32,
  parameter int BW_AXI_DATA     = 64,
  parameter int MAX_NUM_ROW     = 16,
  parameter int MAX_NUM_COL     = 16,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           enable,
  output logic                           busy,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [1:0]                     inst_opcode,
  input  logic [BW_ADDR-1:0]             inst_addr,
  input  logic [BW_ADDR-1:0]             inst_stride,
  input  logic [$clog2(MAX_NUM_ROW)-1:0] inst_num_row_m1,
  input  logic [$clog2(MAX_NUM_COL)-1:0] inst_num_col_m1,
  input  logic [1:0]                     inst_elem_lsa,
  output logic                           txn_valid,
  input  logic                           txn_ready,
  output logic                           txn_write,
  output logic [BW_ADDR-1:0]             txn_addr,
  output logic [7:0]                     txn_len,
  output logic [$clog2(MAX_NUM_ROW)-1:0] txn_row,
  output logic                           txn_last,
  input  logic                           done_valid,
  output logic                           inst_done
);

  localparam int RW    = $clog2(MAX_NUM_ROW);
  localparam int CW    = $clog2(MAX_NUM_COL);
  localparam int BYTES = BW_AXI_DATA / 8;
  localparam int BL    = $clog2(BYTES);
  localparam int BCW   = CW + 4;
  localparam int OW    = $clog2(NUM_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
`ifdef DCA_LSU_4KB_SPLIT_EN
    SPLIT,
`endif
    DRAIN
  } state_t;

  state_t             state, state_next;
  logic               write_reg;
  logic [BW_ADDR-1:0] addr_reg;
  logic [BW_ADDR-1:0] stride_reg;
  logic [RW-1:0]      num_row_m1_reg;
  logic [CW-1:0]      num_col_m1_reg;
  logic [1:0]         elem_lsa_reg;
  logic [RW-1:0]      row_reg;
  logic [7:0]         len_reg;
  logic [OW-1:0]      cnt_reg;

  logic               hs;
  logic               last_row;
  logic               row_adv;
  logic [BCW-1:0]     row_bytes;
  logic [BW_ADDR-1:0] end_addr;
  logic [7:0]         len_full;

  // Row geometry: the burst length counts beats touched from row start to row end.
  assign row_bytes = (BCW'(num_col_m1_reg) + BCW'(1)) << elem_lsa_reg;
  assign end_addr  = addr_reg + BW_ADDR'(row_bytes) - BW_ADDR'(1);
  assign len_full  = 8'((end_addr >> BL) - (addr_reg >> BL));

  assign hs       = txn_valid & txn_ready;
  assign last_row = (row_reg == num_row_m1_reg);

  assign inst_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign txn_write  = write_reg;
  assign txn_row    = row_reg;
  // inst_done is an event, so it only fires in a cycle where the FSM moves on.
  assign inst_done  = enable && (state == DRAIN) && (cnt_reg == '0);

`ifdef DCA_LSU_4KB_SPLIT_EN
  logic               split_reg;
  logic [BW_ADDR-1:0] bnd_addr_reg;
  logic [7:0]         len2_reg;
  logic [BW_ADDR-1:0] page_last;
  logic [BW_ADDR-1:0] bnd_addr;
  logic               cross;
  logic [7:0]         len_first;
  logic [7:0]         len_second;

  // First burst stops at the last byte of the page; the second starts on the next page.
  assign page_last  = addr_reg | BW_ADDR'(12'hFFF);
  assign bnd_addr   = page_last + BW_ADDR'(1);
  assign cross      = (end_addr >> 12) != (addr_reg >> 12);
  assign len_first  = 8'((page_last >> BL) - (addr_reg >> BL));
  assign len_second = 8'((end_addr >> BL) - (bnd_addr >> BL));

  assign txn_valid = ((state == ISSUE) || (state == SPLIT)) && (cnt_reg != OW'(NUM_OUTSTANDING));
  assign txn_addr  = (state == SPLIT) ? bnd_addr_reg : addr_reg;
  assign txn_len   = (state == SPLIT) ? len2_reg : len_reg;
  assign txn_last  = last_row && (((state == ISSUE) && !split_reg) || (state == SPLIT));
  assign row_adv   = hs && (((state == ISSUE) && !split_reg) || (state == SPLIT));

  // Capture the split geometry while the row length is being computed.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      split_reg    <= 1'b0;
      bnd_addr_reg <= '0;
      len2_reg     <= '0;
    end else if (enable && (state == CALC)) begin
      split_reg    <= cross;
      bnd_addr_reg <= bnd_addr;
      len2_reg     <= len_second;
    end
  end
`else
  assign txn_valid = (state == ISSUE) && (cnt_reg != OW'(NUM_OUTSTANDING));
  assign txn_addr  = addr_reg;
  assign txn_len   = len_reg;
  assign txn_last  = last_row && (state == ISSUE);
  assign row_adv   = hs && (state == ISSUE);
`endif

  // State register; the FSM only moves while enabled.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= IDLE;
    else if (enable) state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (inst_valid) begin
          state_next = ((inst_opcode == 2'd1) || (inst_opcode == 2'd2)) ? CALC : DRAIN;
        end
      end
      CALC: state_next = ISSUE;
      ISSUE: begin
        if (hs) begin
`ifdef DCA_LSU_4KB_SPLIT_EN
          if (split_reg) state_next = SPLIT;
          else state_next = last_row ? DRAIN : CALC;
`else
          state_next = last_row ? DRAIN : CALC;
`endif
        end
      end
`ifdef DCA_LSU_4KB_SPLIT_EN
      SPLIT: begin
        if (hs) state_next = last_row ? DRAIN : CALC;
      end
`endif
      DRAIN: begin
        if (cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction fields, per-row length and row/address stepping.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      stride_reg     <= '0;
      num_row_m1_reg <= '0;
      num_col_m1_reg <= '0;
      elem_lsa_reg   <= '0;
      row_reg        <= '0;
      len_reg        <= '0;
    end else if (enable) begin
      if ((state == IDLE) && inst_valid) begin
        write_reg      <= (inst_opcode == 2'd2);
        addr_reg       <= inst_addr;
        stride_reg     <= inst_stride;
        num_row_m1_reg <= inst_num_row_m1;
        num_col_m1_reg <= inst_num_col_m1;
        elem_lsa_reg   <= inst_elem_lsa;
        row_reg        <= '0;
      end
      if (state == CALC) begin
`ifdef DCA_LSU_4KB_SPLIT_EN
        len_reg <= cross ? len_first : len_full;
`else
        len_reg <= len_full;
`endif
      end
      if (row_adv) begin
        row_reg  <= row_reg + RW'(1);
        addr_reg <= addr_reg + stride_reg;
      end
    end
  end

  // Outstanding-burst counter; runs even while the FSM is held by enable.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) cnt_reg <= '0;
    else if (hs && !done_valid) cnt_reg <= cnt_reg + OW'(1);
    else if (!hs && done_valid && (cnt_reg != '0)) cnt_reg <= cnt_reg - OW'(1);
  end

endmodule
